// File: rtl/seg7_pkg.sv
// Shared 7-segment constants (active-high form, bit0=a .. bit6=g).
// The encode and decode paths both use SEG_TABLE so they cannot drift apart.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h67;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Entry d holds the pattern for decimal digit d.
  localparam logic [9:0][6:0] SEG_TABLE = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
                                           SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

endpackage

// File: rtl/seg7_to_dec.sv
// Combinational decode of an active-low segment pattern back to a BCD digit.
// Blank is legal and reports BCD_BLANK; unknown patterns are flagged illegal.
module seg7_to_dec
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n_i,
  output logic [3:0] num_o,
  output logic       legal_o,
  output logic       blank_o
);

  logic [6:0] pat;

  always_comb begin
    pat     = ~seg_n_i;
    num_o   = BCD_BLANK;
    legal_o = 1'b0;
    blank_o = 1'b0;
    if (pat == SEG_BLANK) begin
      legal_o = 1'b1;
      blank_o = 1'b1;
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (pat == SEG_TABLE[i]) begin
          num_o   = 4'(i);
          legal_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Readback monitor for a multiplexed active-low 7-segment bus: filters each
// {segments, select} pair for stability, then commits the decoded digit.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [6:0]              seg_n_i,
  input  logic [NUM_DIGITS-1:0]   dig_sel_i,
  input  logic                    clear_i,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic [NUM_DIGITS-1:0]   digit_valid_o,
  output logic                    frame_valid_o,
  output logic                    err_illegal_o,
  output logic                    err_select_o
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [6:0]              cand_seg_q, cand_seg_d;
  logic [NUM_DIGITS-1:0]   cand_sel_q, cand_sel_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d, mask_next;
  logic                    frame_q, frame_d;
  logic                    err_ill_q, err_ill_d;
  logic                    err_sel_q, err_sel_d;
  logic                    commit;

  logic [3:0] dec_num;
  logic       dec_legal;
  logic       dec_blank;

  seg7_to_dec u_dec (
    .seg_n_i (seg_n_i),
    .num_o   (dec_num),
    .legal_o (dec_legal),
    .blank_o (dec_blank)
  );

  always_comb begin
    cand_seg_d = cand_seg_q;
    cand_sel_d = cand_sel_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    valid_d    = valid_q;
    mask_d     = mask_q;
    mask_next  = mask_q | dig_sel_i;
    frame_d    = 1'b0;
    err_ill_d  = 1'b0;
    err_sel_d  = 1'b0;
    commit     = 1'b0;

    // Clear wins over everything, including a commit and the select error.
    if (clear_i) begin
      bcd_d   = '1;
      valid_d = '0;
      mask_d  = '0;
      cnt_d   = '0;
    end else if (dig_sel_i == '0) begin
      cnt_d = '0;
    end else if (!$onehot(dig_sel_i)) begin
      cnt_d     = '0;
      err_sel_d = 1'b1;
    end else if ({seg_n_i, dig_sel_i} != {cand_seg_q, cand_sel_q}) begin
      cand_seg_d = seg_n_i;
      cand_sel_d = dig_sel_i;
      cnt_d      = CntOne;
    end else if (cnt_q < CntMax) begin
      cnt_d  = cnt_q + CntOne;
      commit = (cnt_q == CntLast);
    end

    if (commit) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (dig_sel_i[i]) begin
          if (dec_blank) begin
            bcd_d[4*i +: 4] = BCD_BLANK;
            valid_d[i]      = 1'b0;
          end else if (dec_legal) begin
            bcd_d[4*i +: 4] = dec_num;
            valid_d[i]      = 1'b1;
          end else begin
            valid_d[i] = 1'b0;
            err_ill_d  = 1'b1;
          end
        end
      end
      if (&mask_next) begin
        frame_d = 1'b1;
        mask_d  = '0;
      end else begin
        mask_d = mask_next;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cand_seg_q <= '0;
      cand_sel_q <= '0;
      cnt_q      <= '0;
      bcd_q      <= '1;
      valid_q    <= '0;
      mask_q     <= '0;
      frame_q    <= 1'b0;
      err_ill_q  <= 1'b0;
      err_sel_q  <= 1'b0;
    end else begin
      cand_seg_q <= cand_seg_d;
      cand_sel_q <= cand_sel_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      valid_q    <= valid_d;
      mask_q     <= mask_d;
      frame_q    <= frame_d;
      err_ill_q  <= err_ill_d;
      err_sel_q  <= err_sel_d;
    end
  end

  assign bcd_o         = bcd_q;
  assign digit_valid_o = valid_q;
  assign frame_valid_o = frame_q;
  assign err_illegal_o = err_ill_q;
  assign err_select_o  = err_sel_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with hand-computed expected values.
module tb_seg7_scan_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_n;
  logic [3:0]  dig_sel;
  logic        clear;
  logic [15:0] bcd;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        err_illegal;
  logic        err_select;

  int n_tests = 0;
  int n_fail  = 0;
  int frame_cnt = 0;
  int ill_cnt   = 0;
  int sel_cnt   = 0;

  always #5 clk = ~clk;

  seg7_scan_capture #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .seg_n_i       (seg_n),
    .dig_sel_i     (dig_sel),
    .clear_i       (clear),
    .bcd_o         (bcd),
    .digit_valid_o (digit_valid),
    .frame_valid_o (frame_valid),
    .err_illegal_o (err_illegal),
    .err_select_o  (err_select)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a pattern for n rising edges; sample 1 ns after each edge.
  task automatic hold(input logic [6:0] seg, input logic [3:0] sel, input int n);
    seg_n   = seg;
    dig_sel = sel;
    repeat (n) begin
      @(posedge clk);
      #1;
      frame_cnt += int'(frame_valid);
      ill_cnt   += int'(err_illegal);
      sel_cnt   += int'(err_select);
    end
  endtask

  function automatic logic [2:0] pulses();
    return {frame_valid, err_illegal, err_select};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; seg_n = 7'h00; dig_sel = 4'b0000; clear = 1'b0;
    hold(7'h00, 4'b0000, 2);
    check("rst_bcd", 32'(bcd), 32'hFFFF);
    check("rst_valid", 32'(digit_valid), 32'h0);
    check("rst_pulses", 32'(pulses()), 32'h0);

    reset = 1'b0;
    hold(7'h00, 4'b0000, 3);
    check("idle_bcd", 32'(bcd), 32'hFFFF);
    check("idle_valid", 32'(digit_valid), 32'h0);

    // "2" on digit 0: edge 3 no commit, edge 4 commits.
    hold(7'h24, 4'b0001, 3);
    check("two_pre_bcd", 32'(bcd), 32'hFFFF);
    hold(7'h24, 4'b0001, 1);
    check("two_bcd", 32'(bcd), 32'hFFF2);
    check("two_valid", 32'(digit_valid), 32'h1);

    // Held only 3 cycles then changed: no commit.
    hold(7'h79, 4'b0001, 3);
    hold(7'h30, 4'b0001, 1);
    check("short_bcd", 32'(bcd), 32'hFFF2);

    clear = 1'b1;
    hold(7'h30, 4'b0000, 1);
    clear = 1'b0;
    check("clear_bcd", 32'(bcd), 32'hFFFF);
    check("clear_valid", 32'(digit_valid), 32'h0);

    // Full frame scan "1234".
    frame_cnt = 0;
    hold(7'h79, 4'b0001, 4);
    hold(7'h24, 4'b0010, 4);
    hold(7'h30, 4'b0100, 4);
    check("scan_noframe", 32'(frame_cnt), 32'd0);
    hold(7'h19, 4'b1000, 4);
    check("scan_frame_now", 32'(frame_valid), 32'h1);
    hold(7'h19, 4'b0000, 1);
    check("scan_frame_once", 32'(frame_cnt), 32'd1);
    check("scan_frame_drop", 32'(frame_valid), 32'h0);
    check("scan_bcd", 32'(bcd), 32'h4321);
    check("scan_valid", 32'(digit_valid), 32'hF);

    // Illegal pattern on digit 2.
    frame_cnt = 0; ill_cnt = 0;
    hold(7'h30, 4'b0100, 3);
    hold(7'h7E, 4'b0100, 4);
    check("ill_pulse_now", 32'(err_illegal), 32'h1);
    hold(7'h7E, 4'b0100, 2);
    check("ill_once", 32'(ill_cnt), 32'd1);
    check("ill_bcd", 32'(bcd), 32'h4321);
    check("ill_valid", 32'(digit_valid), 32'hB);

    // Multi-hot select.
    sel_cnt = 0;
    hold(7'h79, 4'b0011, 3);
    check("msel_count", 32'(sel_cnt), 32'd3);
    check("msel_now", 32'(err_select), 32'h1);
    check("msel_bcd", 32'(bcd), 32'h4321);
    hold(7'h12, 4'b0001, 3);
    check("msel_pre", 32'(bcd), 32'h4321);
    hold(7'h12, 4'b0001, 1);
    check("five_bcd", 32'(bcd), 32'h4325);
    check("msel_sel_idle", 32'(err_select), 32'h0);

    // Blank on digit 1.
    hold(7'h7F, 4'b0010, 4);
    check("blank_bcd", 32'(bcd), 32'h43F5);
    check("blank_valid", 32'(digit_valid), 32'h9);
    check("blank_noframe", 32'(frame_cnt), 32'd0);

    // Reset mid-count.
    hold(7'h78, 4'b1000, 3);
    reset = 1'b1;
    #1;
    check("arst_bcd", 32'(bcd), 32'hFFFF);
    hold(7'h78, 4'b1000, 1);
    reset = 1'b0;
    check("arst_valid", 32'(digit_valid), 32'h0);
    check("arst_pulses", 32'(pulses()), 32'h0);
    hold(7'h78, 4'b1000, 3);
    check("arst_pre", 32'(bcd), 32'hFFFF);
    hold(7'h78, 4'b1000, 1);
    check("seven_bcd", 32'(bcd), 32'h7FFF);
    check("seven_valid", 32'(digit_valid), 32'h8);

    // Clear on the commit edge suppresses the commit.
    hold(7'h00, 4'b0001, 3);
    clear = 1'b1;
    hold(7'h00, 4'b0001, 1);
    clear = 1'b0;
    check("clrc_bcd", 32'(bcd), 32'hFFFF);
    check("clrc_valid", 32'(digit_valid), 32'h0);
    check("clrc_pulses", 32'(pulses()), 32'h0);
    hold(7'h00, 4'b0001, 3);
    check("clrc_pre", 32'(bcd), 32'hFFFF);
    hold(7'h00, 4'b0001, 1);
    check("eight_bcd", 32'(bcd), 32'hFFF8);
    check("eight_valid", 32'(digit_valid), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Inverse of the team's BCD-to-7-segment path: observes a multiplexed, active-low 7-segment display bus and recovers the BCD digit shown at each position.
- Used on the egg-timer board as a display readback and self-check monitor. Each pattern is qualified by a stability filter before it is committed to a per-digit register bank.
- Flags illegal segment patterns and illegal digit selects, and pulses once each time a full frame (every digit) has been captured.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions; must be 1 or more.
- STABLE_CYCLES, 4, consecutive identical cycles required before a commit; must be 2 or more.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- seg_n  input  7  active-low segments; bit0=a … bit6=g.
- dig_sel  input  NUM_DIGITS  active-high digit strobe; legal only when exactly one bit is set.
- clear  input  1  synchronous clear of the capture bank.
- bcd  output  4*NUM_DIGITS  captured digits; digit i occupies bits [4i+3:4i].
- digit_valid  output  NUM_DIGITS  bit i set when digit i holds a legal decimal value.
- frame_valid  output  1  one-cycle pulse when every digit has been committed since the last frame.
- err_illegal  output  1  one-cycle pulse on commit of an undecodable pattern.
- err_select  output  1  one-cycle pulse for every cycle in which dig_sel is multi-hot.

Behaviour:
- Reset values (async, any time): bcd all 4'hF; digit_valid 0; frame_valid, err_illegal, err_select 0; candidate {seg,sel} 0; count 0; frame mask 0.
- Decode uses the active-high pattern p = ~seg_n:
  - 0=7'h3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=67.
  - Blank 7'h00 decodes as 4'hF and is legal but not valid.
  - Any other pattern is illegal.
- Stability filter, evaluated each edge:
  - dig_sel zero: count<=0, no commit.
  - dig_sel multi-hot: count<=0, no commit, err_select<=1.
  - One-hot and {seg_n,dig_sel} differs from the candidate: candidate<=inputs, count<=1.
  - One-hot and equal to the candidate with count<STABLE_CYCLES: count<=count+1.
  - Count saturates at STABLE_CYCLES. A held pattern never re-commits; it must change and re-stabilise.
- Commit happens on the edge where count goes from STABLE_CYCLES-1 to STABLE_CYCLES; outputs are registered on that same edge.
  - Latency: input first sampled at edge 1 and held commits at edge STABLE_CYCLES.
  - Legal digit: bcd slot <= value, digit_valid[i]<=1.
  - Blank: bcd slot <= 4'hF, digit_valid[i]<=0.
  - Illegal: bcd slot unchanged, digit_valid[i]<=0, err_illegal<=1.
  - Every commit type sets frame mask bit i.
- Frame completion: when a commit makes the frame mask all-ones, frame_valid<=1 for one cycle and the mask clears in the same edge. Re-committing an already-captured digit leaves the mask unchanged.
- clear (synchronous): bcd<=all F, digit_valid<=0, frame mask<=0, count<=0. The candidate is retained. clear overrides a commit in the same cycle, so no pulses are produced that cycle.
- Pulse outputs default to 0 on every edge unless set as above.
- Reset mid-count discards progress; after release a full STABLE_CYCLES of stable input is required before a commit.

Decomposition:
- Package seg7_pkg holds:
  - localparam segment constants SEG_0..SEG_9 and SEG_BLANK (active-high form);
  - BCD_BLANK = 4'hF;
  - a shared pattern table, so the encode and decode directions use identical constants.
- Sub-module seg7_to_dec is purely combinational:
  - input seg_n[6:0];
  - outputs num[3:0], legal, blank.
- seg7_scan_capture holds the filter, commit logic and frame logic.

Test Plan:
- Assert reset for 2 cycles → bcd=16'hFFFF, digit_valid=4'b0000, all pulses 0; deassert with dig_sel=0 → nothing changes.
- seg_n=7'h24 ("2"), dig_sel=4'b0001 held 4 cycles → after edge 4 bcd[3:0]=2 and digit_valid=4'b0001. Repeat holding only 3 cycles, then change → no commit.
- Scan "1","2","3","4" (seg_n 7'h79,24,30,19) on dig_sel 0001,0010,0100,1000, 4 cycles each → bcd=16'h4321, digit_valid=4'hF, frame_valid high exactly one cycle, on the 4th commit edge.
- seg_n=7'h7E (segment a only) on digit 2 held 4 cycles, after digit 2 previously held 3 → err_illegal one pulse, bcd[11:8] stays 3, digit_valid[2]=0.
- dig_sel=4'b0011 for 3 cycles with a stable pattern → err_select high on all 3 cycles, no commit. Then a one-hot select needs a full 4 cycles to commit.
- Hold a pattern for 3 cycles, pulse reset 1 cycle → outputs return to reset values. After release the same pattern commits only after 4 more edges. Also: clear asserted on a commit edge → no update, no pulses.
